// File: rtl/ucode_loader_pkg.sv
// Shared definitions for the serial uCode boot loader: sync byte and FSM state encodings.
package ucode_loader_pkg;

  localparam logic [7:0] LDR_SYNC = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_BASE_H,
    ST_BASE_L,
    ST_CNT_H,
    ST_CNT_L,
    ST_DATA_H,
    ST_DATA_L,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } ldr_state_e;

endpackage

// File: rtl/ucode_loader.sv
// Serial boot loader: assembles big-endian frames from a byte stream, writes uCode
// words into program memory and raises o_run once the frame checksum matches.
module ucode_loader
  import ucode_loader_pkg::*;
#(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 10,
  parameter int TIMEOUT = 480_000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rx_wr,
  input  logic [7:0]         i_rx_data,
  output logic               o_uc_wr,
  output logic [ADDR_SZ-1:0] o_uc_waddr,
  output logic [DATA_SZ-1:0] o_uc_wdata,
  output logic               o_busy,
  output logic               o_run,
  output logic               o_error
);

  localparam int SUM_W = ADDR_SZ + 7;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [SUM_W-1:0] MEM_MAX = SUM_W'(1) << ADDR_SZ;

  ldr_state_e         state, state_nx;
  logic [TMR_W-1:0]   timer;
  logic [7:0]         csum;
  logic [15:0]        idx;
  logic [15:0]        base;
  logic [15:0]        cnt;
  logic [7:0]         hi;
  logic               timeout;
  logic               accept;
  logic               wr_vld_p1;
  logic [ADDR_SZ-1:0] waddr_p1;
  logic [DATA_SZ-1:0] wdata_p1;

  // Whole window [base, base+count) must sit inside program memory.
  function automatic logic span_ok(input logic [15:0] b, input logic [15:0] c);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(b[ADDR_SZ-1:0]) + SUM_W'(c);
    return (b[15:ADDR_SZ] == '0) && (sum <= MEM_MAX);
  endfunction

  assign o_busy  = !(state inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign o_run   = (state == ST_DONE);
  assign o_error = (state == ST_ERROR);
  assign timeout = o_busy && (timer == TMR_W'(TIMEOUT - 1));
  assign accept  = i_rx_wr && !timeout;

  assign o_uc_wr    = wr_vld_p1;
  assign o_uc_waddr = waddr_p1;
  assign o_uc_wdata = wdata_p1;

  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = ST_ERROR;
    end else if (i_rx_wr) begin
      case (state)
        ST_IDLE, ST_ERROR: if (i_rx_data == LDR_SYNC) state_nx = ST_BASE_H;
        ST_BASE_H: state_nx = ST_BASE_L;
        ST_BASE_L: state_nx = ST_CNT_H;
        ST_CNT_H:  state_nx = ST_CNT_L;
        ST_CNT_L: begin
          if (!span_ok(base, {cnt[15:8], i_rx_data})) state_nx = ST_ERROR;
          else if ({cnt[15:8], i_rx_data} == 16'd0)   state_nx = ST_CHECK;
          else                                        state_nx = ST_DATA_H;
        end
        ST_DATA_H: state_nx = ST_DATA_L;
        ST_DATA_L: state_nx = ((idx + 16'd1) == cnt) ? ST_CHECK : ST_DATA_H;
        ST_CHECK:  state_nx = (i_rx_data == csum) ? ST_DONE : ST_ERROR;
        default:   state_nx = state;
      endcase
    end
  end

  // Control state plus the registered write port (p1: one clock after the lo byte).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      csum      <= '0;
      idx       <= '0;
      wr_vld_p1 <= 1'b0;
      waddr_p1  <= '0;
      wdata_p1  <= '0;
    end else begin
      state     <= state_nx;
      timer     <= (!o_busy || i_rx_wr) ? '0 : timer + TMR_W'(1);
      wr_vld_p1 <= accept && (state == ST_DATA_L);
      if (accept) begin
        if ((state == ST_IDLE || state == ST_ERROR) && i_rx_data == LDR_SYNC) begin
          csum <= '0;
          idx  <= '0;
        end else if (state inside {ST_BASE_H, ST_BASE_L, ST_CNT_H, ST_CNT_L,
                                   ST_DATA_H, ST_DATA_L}) begin
          csum <= csum ^ i_rx_data;
        end
        if (state == ST_DATA_L) begin
          waddr_p1 <= base[ADDR_SZ-1:0] + idx[ADDR_SZ-1:0];
          wdata_p1 <= DATA_SZ'({hi, i_rx_data});
          idx      <= idx + 16'd1;
        end
      end
    end
  end

  // Frame header and hi-byte holding registers carry no reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      case (state)
        ST_BASE_H: base[15:8] <= i_rx_data;
        ST_BASE_L: base[7:0]  <= i_rx_data;
        ST_CNT_H:  cnt[15:8]  <= i_rx_data;
        ST_CNT_L:  cnt[7:0]   <= i_rx_data;
        ST_DATA_H: hi         <= i_rx_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ucode_loader.sv
// Directed bench for ucode_loader with a short inter-byte timeout.
module tb_ucode_loader;

  localparam int DATA_SZ = 16;
  localparam int ADDR_SZ = 10;
  localparam int TIMEOUT = 16;

  logic               clk;
  logic               rst;
  logic               rx_wr;
  logic [7:0]         rx_data;
  logic               uc_wr;
  logic [ADDR_SZ-1:0] uc_waddr;
  logic [DATA_SZ-1:0] uc_wdata;
  logic               busy;
  logic               run;
  logic               err;

  int n_vec = 0;
  int n_bad = 0;
  int wr_count = 0;
  int w0;
  logic               last_wr;
  logic [ADDR_SZ-1:0] last_addr;
  logic [DATA_SZ-1:0] last_data;

  ucode_loader #(.DATA_SZ(DATA_SZ), .ADDR_SZ(ADDR_SZ), .TIMEOUT(TIMEOUT)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_wr    (rx_wr),
    .i_rx_data  (rx_data),
    .o_uc_wr    (uc_wr),
    .o_uc_waddr (uc_waddr),
    .o_uc_wdata (uc_wdata),
    .o_busy     (busy),
    .o_run      (run),
    .o_error    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (uc_wr) wr_count++;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // One byte strobe; the write port is sampled on the negedge after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1 rx_wr = 1'b1; rx_data = b;
    @(posedge clk); #1 rx_wr = 1'b0;
    @(negedge clk);
    last_wr   = uc_wr;
    last_addr = uc_waddr;
    last_data = uc_wdata;
  endtask

  task automatic send_good_frame(input string tag);
    w0 = wr_count;
    send_byte(8'hA5);
    check_vec({tag, "_err_clr"}, 32'(err), 32'd0);
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h02);
    check_vec({tag, "_busy"}, 32'(busy), 32'd1);
    send_byte(8'h12);
    check_vec({tag, "_no_wr_hi"}, 32'(last_wr), 32'd0);
    send_byte(8'h34);
    check_vec({tag, "_wr0"}, 32'(last_wr), 32'd1);
    check_vec({tag, "_addr0"}, 32'(last_addr), 32'h010);
    check_vec({tag, "_data0"}, 32'(last_data), 32'h1234);
    @(negedge clk);
    check_vec({tag, "_wr0_pulse"}, 32'(uc_wr), 32'd0);
    send_byte(8'hAB); send_byte(8'hCD);
    check_vec({tag, "_wr1"}, 32'(last_wr), 32'd1);
    check_vec({tag, "_addr1"}, 32'(last_addr), 32'h011);
    check_vec({tag, "_data1"}, 32'(last_data), 32'hABCD);
    send_byte(8'h52);
    check_vec({tag, "_run"}, 32'(run), 32'd1);
    check_vec({tag, "_err"}, 32'(err), 32'd0);
    check_vec({tag, "_busy_done"}, 32'(busy), 32'd0);
    check_vec({tag, "_nwr"}, 32'(wr_count - w0), 32'd2);
  endtask

  initial begin
    rst = 1'b0; rx_wr = 1'b0; rx_data = 8'h00;

    // 1: reset state and ignored idle bytes
    do_reset();
    check_vec("rst_wr",    32'(uc_wr),    32'd0);
    check_vec("rst_waddr", 32'(uc_waddr), 32'd0);
    check_vec("rst_wdata", 32'(uc_wdata), 32'd0);
    check_vec("rst_busy",  32'(busy),     32'd0);
    check_vec("rst_run",   32'(run),      32'd0);
    check_vec("rst_err",   32'(err),      32'd0);
    w0 = wr_count;
    send_byte(8'h00); send_byte(8'hFF);
    check_vec("idle_busy", 32'(busy), 32'd0);
    check_vec("idle_err",  32'(err),  32'd0);
    check_vec("idle_nwr",  32'(wr_count - w0), 32'd0);

    // 2: good frame, then DONE ignores a new sync
    send_good_frame("good");
    send_byte(8'hA5);
    check_vec("done_hold_busy", 32'(busy), 32'd0);
    check_vec("done_hold_run",  32'(run),  32'd1);

    // 3: bad checksum
    do_reset();
    w0 = wr_count;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h53);
    check_vec("badck_err",  32'(err),  32'd1);
    check_vec("badck_run",  32'(run),  32'd0);
    check_vec("badck_busy", 32'(busy), 32'd0);
    check_vec("badck_nwr",  32'(wr_count - w0), 32'd2);

    // 4: range violations
    do_reset();
    w0 = wr_count;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'hFF); send_byte(8'h00);
    check_vec("range1_pre", 32'(err), 32'd0);
    send_byte(8'h02);
    check_vec("range1_err",  32'(err),  32'd1);
    check_vec("range1_busy", 32'(busy), 32'd0);
    send_byte(8'h12); send_byte(8'h34);
    check_vec("range1_nwr", 32'(wr_count - w0), 32'd0);
    send_byte(8'hA5);
    check_vec("range2_clr", 32'(err), 32'd0);
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    check_vec("range2_err", 32'(err), 32'd1);
    send_byte(8'h12); send_byte(8'h34);
    check_vec("range2_nwr", 32'(wr_count - w0), 32'd0);

    // 5: inter-byte timeout, then recovery with a good frame
    do_reset();
    send_byte(8'hA5); send_byte(8'h00);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check_vec("tmo_early_err",  32'(err),  32'd0);
    check_vec("tmo_early_busy", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_vec("tmo_err",  32'(err),  32'd1);
    check_vec("tmo_busy", 32'(busy), 32'd0);
    send_good_frame("recov");

    // 6: zero-count frame, then reset after a DATA_H byte
    do_reset();
    w0 = wr_count;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00);
    check_vec("zero_run", 32'(run), 32'd1);
    check_vec("zero_nwr", 32'(wr_count - w0), 32'd0);
    do_reset();
    w0 = wr_count;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h12);
    do_reset();
    check_vec("midrst_busy", 32'(busy), 32'd0);
    check_vec("midrst_run",  32'(run),  32'd0);
    send_byte(8'h34);
    check_vec("midrst_nwr",  32'(wr_count - w0), 32'd0);
    check_vec("midrst_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
